// File: rtl/mem_access_unit.sv
// Load/store unit between the core and a word-wide 1 KiB data memory.
// Handles sub-word stores by read-modify-write, extended sub-word loads and misalignment faults.
module mem_access_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [9:0]  mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_we,
  input  logic [31:0] mem_dout
);

  typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_t;

  state_t      state_reg, state_next;
  logic        we_reg;
  logic [1:0]  size_reg;
  logic        unsigned_reg;
  logic [9:0]  addr_reg;
  logic [31:0] wdata_reg;
  logic [31:0] merge_reg;
  logic        resp_valid_reg;
  logic [31:0] resp_rdata_reg;
  logic        resp_fault_reg;

  logic        misaligned;
  logic [4:0]  shamt;
  logic [31:0] lane;
  logic [31:0] lane_mask;
  logic [31:0] load_data;
  logic [31:0] merged;
  logic        unused_bits;

  // Size 3 decodes as word everywhere, so size[1] alone means "word".
  assign misaligned = ((req_size == 2'd1) && req_addr[0]) ||
                      (req_size[1] && (req_addr[1:0] != 2'b00));

  assign shamt     = {addr_reg[1:0], 3'b000};
  assign lane      = mem_dout >> shamt;
  assign lane_mask = (size_reg == 2'd0) ? 32'h0000_00ff : 32'h0000_ffff;
  assign merged    = (mem_dout & ~(lane_mask << shamt)) | ((wdata_reg & lane_mask) << shamt);

  always_comb begin
    load_data = mem_dout;
    case (size_reg)
      2'd0: load_data = unsigned_reg ? {24'h0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
      2'd1: load_data = unsigned_reg ? {16'h0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: load_data = mem_dout;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          if (misaligned)       state_next = RESP;
          else if (!req_we)     state_next = LOAD;
          else if (req_size[1]) state_next = WRITE;
          else                  state_next = RMW_RD;
        end
      end
      LOAD:    state_next = RESP;
      RMW_RD:  state_next = WRITE;
      WRITE:   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      we_reg         <= 1'b0;
      size_reg       <= 2'd0;
      unsigned_reg   <= 1'b0;
      addr_reg       <= 10'd0;
      wdata_reg      <= 32'd0;
      merge_reg      <= 32'd0;
      resp_valid_reg <= 1'b0;
      resp_rdata_reg <= 32'd0;
      resp_fault_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      resp_valid_reg <= (state_next == RESP);
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            we_reg         <= req_we;
            size_reg       <= req_size;
            unsigned_reg   <= req_unsigned;
            addr_reg       <= req_addr[9:0];
            wdata_reg      <= req_wdata;
            merge_reg      <= req_wdata;
            resp_rdata_reg <= 32'd0;
            resp_fault_reg <= misaligned;
          end
        end
        LOAD:    resp_rdata_reg <= load_data;
        RMW_RD:  merge_reg      <= merged;
        default: ;
      endcase
    end
  end

  assign req_ready  = (state_reg == IDLE);
  assign resp_valid = resp_valid_reg;
  assign resp_rdata = resp_rdata_reg;
  assign resp_fault = resp_fault_reg;
  // Reset gating keeps a WRITE interrupted by reset from reaching memory.
  assign mem_we     = (state_reg == WRITE) && rst_n;
  assign mem_din    = merge_reg;
  assign mem_addr   = (state_reg == IDLE) ? {req_addr[9:2], 2'b00} : {addr_reg[9:2], 2'b00};

  assign unused_bits = ^{req_addr[31:10], we_reg};

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural word memory and
// hand-computed expectations.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [9:0]  mem_addr;
  logic [31:0] mem_din;
  logic        mem_we;
  logic [31:0] mem_dout;

  logic [31:0] mem [0:255];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign mem_dout = mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[9:2]] <= mem_din;

  mem_access_unit dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_fault(resp_fault), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_we(mem_we), .mem_dout(mem_dout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request at cycle C and wait (bounded) for its response.
  task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                        input int exp_lat, input logic [31:0] exp_rdata,
                        input logic exp_fault, input logic exp_we);
    int lat;
    logic [31:0] rd;
    logic ft;
    logic we_seen;
    lat = 0;
    rd = 32'hxxxx_xxxx;
    ft = 1'bx;
    @(negedge clk);
    chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    we_seen = mem_we;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int n = 1; n <= 6 && lat == 0; n++) begin
      @(negedge clk);
      if (mem_we) we_seen = 1'b1;
      if (resp_valid) begin
        lat = n; rd = resp_rdata; ft = resp_fault;
      end
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_rdata"}, rd, exp_rdata);
    chk({tag, "_fault"}, {31'd0, ft}, {31'd0, exp_fault});
    chk({tag, "_memwe"}, {31'd0, we_seen}, {31'd0, exp_we});
    $display("txn %-10s we=%0b size=%0d addr=%h wdata=%h lat=%0d rdata=%h fault=%0b",
             tag, we, size, addr, wdata, lat, rd, ft);
  endtask

  initial begin
    int accepts;
    int last_acc;
    logic bad_gap;
    logic saw_resp;
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;

    // Reset for two cycles
    @(negedge clk);
    chk("rst_memwe0", {31'd0, mem_we}, 32'd0);
    @(negedge clk);
    chk("rst_memwe1", {31'd0, mem_we}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_respv", {31'd0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_fault", {31'd0, resp_fault}, 32'd0);
    $display("txn reset ready=%0b resp_valid=%0b rdata=%h", req_ready, resp_valid, resp_rdata);

    // Store word and extended loads
    do_req("sw10",  1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 2, 32'h0, 1'b0, 1'b1);
    chk("mem10", mem[4], 32'hDEADBEEF);
    do_req("lw10",  1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 2, 32'hDEADBEEF, 1'b0, 1'b0);
    do_req("lbu13", 1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 2, 32'h000000DE, 1'b0, 1'b0);
    do_req("lb10",  1'b0, 2'd0, 1'b0, 32'h10, 32'h0, 2, 32'hFFFFFFEF, 1'b0, 1'b0);
    do_req("lhu12", 1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 2, 32'h0000DEAD, 1'b0, 1'b0);
    do_req("lh10",  1'b0, 2'd1, 1'b0, 32'h10, 32'h0, 2, 32'hFFFFBEEF, 1'b0, 1'b0);
    do_req("ld3_10", 1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 2, 32'hDEADBEEF, 1'b0, 1'b0);

    // Read-modify-write
    do_req("sw20",  1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, 2, 32'h0, 1'b0, 1'b1);
    do_req("sb21",  1'b1, 2'd0, 1'b0, 32'h21, 32'hFFFFFFAA, 3, 32'h0, 1'b0, 1'b1);
    do_req("lw20a", 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 2, 32'h1122AA44, 1'b0, 1'b0);
    do_req("sh22",  1'b1, 2'd1, 1'b0, 32'h22, 32'hABCD5566, 3, 32'h0, 1'b0, 1'b1);
    do_req("lw20b", 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 2, 32'h5566AA44, 1'b0, 1'b0);

    // Misalignment
    mem[12] = 32'h99887766;
    do_req("lw22",  1'b0, 2'd2, 1'b0, 32'h22, 32'h0, 1, 32'h0, 1'b1, 1'b0);
    do_req("sh31",  1'b1, 2'd1, 1'b0, 32'h31, 32'h0000BBBB, 1, 32'h0, 1'b1, 1'b0);
    chk("mem30", mem[12], 32'h99887766);
    do_req("lbu31", 1'b0, 2'd0, 1'b1, 32'h31, 32'h0, 2, 32'h00000077, 1'b0, 1'b0);

    // Reset during the WRITE cycle of a byte store
    mem[16] = 32'h01020304;
    @(negedge clk);
    req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h40; req_wdata = 32'h000000FF; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_in_write", {31'd0, mem_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_memwe", {31'd0, mem_we}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_resp = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (resp_valid) saw_resp = 1'b1;
    end
    chk("abort_mem40", mem[16], 32'h01020304);
    chk("abort_noresp", {31'd0, saw_resp}, 32'd0);
    chk("abort_ready", {31'd0, req_ready}, 32'd1);
    $display("txn abort mem40=%h resp_seen=%0b ready=%0b", mem[16], saw_resp, req_ready);

    // Aliasing
    do_req("sw400", 1'b1, 2'd2, 1'b0, 32'h400, 32'hCAFEF00D, 2, 32'h0, 1'b0, 1'b1);
    do_req("lw000", 1'b0, 2'd2, 1'b0, 32'h000, 32'h0, 2, 32'hCAFEF00D, 1'b0, 1'b0);

    // Hold-off with req_valid held high: loads accept every 3 cycles
    @(negedge clk);
    req_we = 1'b0; req_size = 2'd2; req_addr = 32'h10; req_valid = 1'b1;
    accepts = 0; last_acc = -10; bad_gap = 1'b0;
    for (int n = 0; n < 21; n++) begin
      if (req_valid && req_ready) begin
        if (accepts > 0 && (n - last_acc) != 3) bad_gap = 1'b1;
        accepts++;
        last_acc = n;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("hold_accepts", accepts, 7);
    chk("hold_gap", {31'd0, bad_gap}, 32'd0);
    $display("txn holdoff accepts=%0d bad_gap=%0b", accepts, bad_gap);

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store unit between the CPU datapath and the byte-addressed 1 KiB data memory. Accepts one load or store request at a time from the core over a valid/ready handshake. Drives the memory's word-wide port: `addr[9:0]`, `din[31:0]`, `WriteEn`, and a combinational `dout[31:0]`, with writes committed at posedge `clk`. Adds byte and halfword stores via read-modify-write, sign- or zero-extended sub-word loads, and alignment fault reporting.

## Interface
- No parameters. Memory depth is fixed at 1024 bytes; data width is fixed at 32.

Ports, clock and reset first:
- `clk` in 1: single clock. Everything is synchronous to its rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `req_valid` in 1: core presents a request.
- `req_ready` out 1: unit can accept a request. High only in IDLE.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 0 = byte, 1 = halfword, 2 = word. 3 is treated as word.
- `req_unsigned` in 1: for loads, zero-extend when 1, sign-extend when 0.
- `req_addr` in 32: byte address. Bits [31:10] are ignored, so addresses alias.
- `req_wdata` in 32: store data. Sub-word data is taken from the low bits.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: extended load data. 0 for stores and faults.
- `resp_fault` out 1: misaligned access, qualified by `resp_valid`.
- `mem_addr` out 10: word-aligned memory address; bits [1:0] are always 0.
- `mem_din` out 32: write data to memory.
- `mem_we` out 1: memory write enable.
- `mem_dout` in 32: combinational read data from memory.

## Operation
- Little-endian layout. Byte k of a word is bits [8k+7:8k]. The halfword at `addr[1]`=h is bits [16h+15:16h].
- States: IDLE, LOAD, RMW_RD, WRITE, RESP.
- IDLE, when `req_valid` is high:
  - Latch `we`, `size`, `unsigned`, `addr[9:0]` and `wdata`.
  - Misaligned means a halfword with `addr[0]`=1, or a word with `addr[1:0]`≠0. A misaligned request goes to RESP with the fault flag set and never touches memory.
  - An aligned load goes to LOAD.
  - An aligned store word goes to WRITE, with `merge` = `wdata`.
  - An aligned store byte or halfword goes to RMW_RD.
- LOAD: sample `mem_dout`, then select and extend the addressed byte, halfword or word into `resp_rdata`. Next state is RESP.
- RMW_RD: sample `mem_dout` and replace only the addressed byte or halfword lane with the low bits of `wdata`, giving `merge`. All other lanes are preserved. Next state is WRITE.
- WRITE: `mem_we`=1 and `mem_din`=`merge`; the memory commits at the edge that ends this state. Next state is RESP.
- RESP: `resp_valid`=1 for exactly one cycle, then IDLE.
- `mem_addr` is `{latched_addr[9:2],2'b00}` in all non-IDLE states. In IDLE it is `{req_addr[9:2],2'b00}`.
- `req_valid` is ignored outside IDLE, because `req_ready`=0 there.
- Reset, when `rst_n` is sampled 0 at an edge:
  - State goes to IDLE.
  - Registered outputs clear: `resp_valid`=0, `resp_rdata`=0, `resp_fault`=0, `mem_din`=0.
  - `mem_we` is gated with `rst_n`, so no memory write occurs on any cycle where `rst_n`=0, including a WRITE aborted by reset.
  - An aborted request produces no response.
  - After reset, `req_ready`=1 and `mem_we`=0.

## Timing
- Latency is counted from the accept cycle C, where `req_valid`&&`req_ready` is high:

  | Access | `resp_valid` high in cycle |
  |---|---|
  | Fault | C+1 |
  | Load or store word | C+2 |
  | Store byte or halfword | C+3 |

- For stores, memory holds the new word from cycle C+2 (word) or C+3 (sub-word) onward.
- The earliest next accept is the cycle after RESP. There is no back-to-back accept; throughput is at most one request per 3 cycles.
- `resp_rdata` and `resp_fault` are valid only while `resp_valid`=1. Both are 0 after reset.
- `req_ready` is a combinational decode of the state. `mem_we`, `mem_addr` and `mem_din` are combinational from state and the latched registers only, never from `mem_dout`, so there is no combinational loop.

## Test plan
- Reset with `rst_n`=0 for 2 cycles:
  - During reset, `mem_we`=0.
  - After release, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0.
- Store-word then load, both at address 0x10:
  - SW 0xDEADBEEF: response at C+2 with `resp_fault`=0.
  - LW: `resp_rdata`=0xDEADBEEF.
  - LBU at 0x13 returns 0x000000DE.
  - LB at 0x10 returns 0xFFFFFFEF.
  - LHU at 0x12 returns 0x0000DEAD.
  - LH at 0x10 returns 0xFFFFBEEF.
- Read-modify-write:
  - Preload 0x11223344 at 0x20.
  - SB 0xAA at 0x21: response at C+3, then LW 0x20 = 0x1122AA44.
  - SH 0x5566 at 0x22, then LW 0x20 = 0x5566AA44.
- Misalignment:
  - LW 0x22: `resp_valid` at C+1, `resp_fault`=1, `resp_rdata`=0.
  - SH 0x31: fault, `mem_we` never asserted, memory word unchanged.
- Reset mid-operation:
  - Drop `rst_n` during the WRITE cycle of an SB to 0x40 holding 0x01020304.
  - The word stays 0x01020304, no `resp_valid` is produced, and `req_ready`=1 after reset.
- Aliasing and hold-off:
  - SW 0xCAFEF00D at 0x400 followed by LW 0x000 returns 0xCAFEF00D.
  - `req_valid` held high throughout yields exactly one accept per 3-4 cycles, never two in a row.
